serial_sort_engine: RTL and testbench
=====================================

# serial_sort_engine

Frame-based serial sorter: accepts N unsigned words one per cycle over a valid/ready stream, sorts them in place with an iterated odd-even transposition compare-exchange stage (one layer per clock), then streams them out in sorted order with each word's original arrival index. It is the stream-side counterpart of the parallel combinational comparator network. It sits between a word producer and a consumer that cannot accept N parallel buses, trading N comparators per layer for N clock cycles of sorting.

## Interface
- WIDTH, 32, data word width; compare is unsigned.
- N, 6, words per frame; even, ≥ 2.
- IDX_W, 3, index width; must satisfy 2^IDX_W ≥ N.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  engine accepts a word this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  WIDTH  sorted word.
- out_idx  out  IDX_W  arrival position (0..N-1) of out_data within its frame.
- out_last  out  1  high with the final (Nth) output word of a frame.
- busy  out  1  high in SORT and DRAIN.

## Operation
- Storage: N slots, each {data[WIDTH], idx[IDX_W]}. Counter cnt, 0..N-1.
- FSM states: LOAD, SORT, DRAIN.
- LOAD: in_ready=1. On in_valid&in_ready, write slot[cnt] ← {in_data, cnt}, cnt++. On accepting word N-1: cnt←0, go to SORT.
- SORT: in_ready=0. One layer per cycle for N cycles (pass p=0..N-1). Even p: compare-exchange pairs (0,1),(2,3),…,(N-2,N-1). Odd p: pairs (1,2),(3,4),…,(N-3,N-2); slots 0 and N-1 unchanged. Exchange swaps data and idx together. After pass N-1, go to DRAIN with read pointer 0.
- Compare-exchange (ascending): swap only if lo.data > hi.data, strictly. Equal keys never swap → sort is stable; equal data emerge in increasing idx.
- DRAIN: out_valid=1, out_data/out_idx = slot[rd], out_last = (rd==N-1). On out_valid&out_ready, rd++; on transfer of rd==N-1 go to LOAD with cnt=0.
- No frame overlap: input is refused throughout SORT and DRAIN.

## Timing
- Reset (async assert): state LOAD, cnt=0, rd=0, all slots 0. Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0.
- Accept of last input word at edge E → SORT passes on edges E+1..E+N → out_valid high after edge E+N (N-cycle latency, no dependence on data).
- Throughput with out_ready held high: one frame per 3N cycles (N load, N sort, N drain).
- Input gaps (in_valid low) in LOAD pause cnt; no timeout.
- out_ready low in DRAIN: out_valid stays 1, out_data/out_idx/out_last held stable until transfer.
- in_valid during SORT/DRAIN: ignored, no state change.
- Reset mid-LOAD/SORT/DRAIN: partial frame discarded; next accepted word is slot 0 of a new frame.
- busy asserted from the cycle after the final accept until the cycle after the final output transfer.

## Configuration
- SORT_DESCENDING_EN defined: swap only if lo.data < hi.data (strict); output is largest first; ties still not swapped (stable).
- Not defined: ascending order as above, smallest first.

## Test plan
- Ascending, out_ready=1: in 4,1,2,5,3,7 → out_data 1,2,3,4,5,7; out_idx 1,2,4,0,3,5; out_last only on 7.
- Stability: in 16,11,12,16,12,10 → out 10,11,12,12,16,16; idx 5,1,2,4,0,3.
- Latency/handshake: continuous in_valid; out_valid rises exactly 6 cycles after the 6th accept; in_ready=0 from the 6th accept until the last output transfer.
- Backpressure: in 1,16,12,14,15,8; drop out_ready for 3 cycles after the 2nd output → out 8,12 then held 12 stable, resumes 14,15,16; idx 5,2,3,4,1.
- Reset mid-SORT: load 3,4,9,19,2,9, assert rst 2 cycles into SORT → all outputs at reset values; then load 13,9,2,1,18,20 → out 1,2,9,13,18,20.
- With SORT_DESCENDING_EN: in 10,17,18,1,16,4 → out 18,17,16,10,4,1; idx 2,1,4,0,5,3.

Source files
------------

// File: rtl/serial_sort_engine.sv
// serial_sort_engine
// Frame-based serial sorter: loads N words over a valid/ready stream, sorts
// them with N layers of odd-even transposition compare-exchange (one layer
// per clock), then streams them out with each word's arrival index.
// Optional build macro: SORT_DESCENDING_EN (largest first when defined).
module serial_sort_engine #(
    parameter int WIDTH = 32,
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;          // load position in LOAD, pass number in SORT
    logic [IDX_W-1:0] r_rd;           // read pointer in DRAIN
    logic [WIDTH-1:0] r_data [N];
    logic [IDX_W-1:0] r_idx  [N];
    logic [WIDTH-1:0] w_data [N];     // slot contents after this cycle's layer
    logic [IDX_W-1:0] w_idx  [N];
    logic             w_cnt_last;
    logic             w_rd_last;

    assign w_cnt_last = (r_cnt == IDX_W'(N - 1));
    assign w_rd_last  = (r_rd  == IDX_W'(N - 1));

    // Strict comparison: equal keys never swap, which keeps the sort stable.
    function automatic logic f_swap(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
`ifdef SORT_DESCENDING_EN
        return lo < hi;
`else
        return lo > hi;
`endif
    endfunction

    // One compare-exchange layer; pass parity selects even or odd pairs.
    always_comb begin
        // NOTE: every slot gets its pass-through value first so the
        // conditional swaps below cannot infer latches.
        for (int k = 0; k < N; k++) begin
            w_data[k] = r_data[k];
            w_idx[k]  = r_idx[k];
        end
        for (int k = 0; k < N - 1; k++) begin
            if ((k[0] == r_cnt[0]) && f_swap(r_data[k], r_data[k+1])) begin
                w_data[k]   = r_data[k+1];
                w_data[k+1] = r_data[k];
                w_idx[k]    = r_idx[k+1];
                w_idx[k+1]  = r_idx[k];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) r_state <= LOAD;
        else     r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOAD:    if (in_valid && w_cnt_last)  w_next = SORT;
            SORT:    if (w_cnt_last)              w_next = DRAIN;
            DRAIN:   if (out_ready && w_rd_last)  w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // FSM outputs; data outputs are forced to zero outside DRAIN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (r_state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SORT: ;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = r_data[r_rd];
                out_idx   = r_idx[r_rd];
                out_last  = w_rd_last;
            end
            default: busy = 1'b0;
        endcase
    end

    // Slot storage, load/pass counter and read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot array is reset explicitly so a reset leaves no
            // stale words visible; it is small enough to live in flops.
            for (int k = 0; k < N; k++) begin
                r_data[k] <= '0;
                r_idx[k]  <= '0;
            end
            r_cnt <= '0;
            r_rd  <= '0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        r_data[r_cnt] <= in_data;
                        r_idx[r_cnt]  <= r_cnt;
                        r_cnt         <= w_cnt_last ? '0 : r_cnt + IDX_W'(1);
                    end
                    r_rd <= '0;
                end
                SORT: begin
                    for (int k = 0; k < N; k++) begin
                        r_data[k] <= w_data[k];
                        r_idx[k]  <= w_idx[k];
                    end
                    r_cnt <= w_cnt_last ? '0 : r_cnt + IDX_W'(1);
                    r_rd  <= '0;
                end
                DRAIN: begin
                    if (out_ready) r_rd <= w_rd_last ? '0 : r_rd + IDX_W'(1);
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                    r_rd  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sort_engine.sv
// tb_serial_sort_engine
// Drives directed and random frames into serial_sort_engine and compares the
// output stream against a stable insertion-sort reference model.
// Honours SORT_DESCENDING_EN the same way the design does.
module tb_serial_sort_engine;

    localparam int N  = 6;
    localparam int W  = 32;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_sort_engine #(.WIDTH(W), .N(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // True when a must be output before b (strict, so ties keep arrival order).
    function automatic bit precedes(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SORT_DESCENDING_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    // Reference: stable insertion sort of (data, arrival index) pairs.
    task automatic model(input logic [W-1:0] w [N], output logic [W-1:0] d [N],
                         output logic [IW-1:0] x [N]);
        logic [W-1:0]  td;
        logic [IW-1:0] tx;
        for (int i = 0; i < N; i++) begin
            d[i] = w[i];
            x[i] = IW'(i);
        end
        for (int i = 1; i < N; i++) begin
            int p = i;
            while (p > 0 && precedes(d[p], d[p-1])) begin
                td = d[p]; d[p] = d[p-1]; d[p-1] = td;
                tx = x[p]; x[p] = x[p-1]; x[p-1] = tx;
                p--;
            end
        end
    endtask

    task automatic load_words(input logic [W-1:0] w [N], input bit gaps, input string name);
        for (int i = 0; i < N; i++) begin
            if (gaps && $urandom_range(2) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = w[i];
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s load_ready word %0d: got %b want 1", name, i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // stall: 0 = out_ready held high, 1 = random, 2 = 3-cycle drop on 2nd output
    task automatic run_frame(input logic [W-1:0] w [N], input bit gaps, input int stall,
                             input string name);
        logic [W-1:0]  ed [N];
        logic [IW-1:0] ei [N];
        int j, cyc, hold;
        model(w, ed, ei);
        load_words(w, gaps, name);
        // N sort cycles: no output, no input accepted, busy high; in_valid noise ignored
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if ({out_valid, in_ready, busy} !== 3'b001) begin
                n_err++;
                $display("FAIL %s sort_phase cycle %0d: valid/ready/busy got %b want 001",
                         name, k, {out_valid, in_ready, busy});
            end
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            @(posedge clk); #1;
        end
        j = 0; cyc = 0; hold = 0;
        while (j < N && cyc < 100) begin
            case (stall)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(1));
                default: begin
                    out_ready = !(j == 1 && hold < 3);
                    if (j == 1 && hold < 3) hold++;
                end
            endcase
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            n_cmp++;
            if ({out_valid, in_ready, busy, out_last} !== {3'b101, (j == N - 1)}) begin
                n_err++;
                $display("FAIL %s drain_ctrl word %0d: valid/ready/busy/last got %b want %b",
                         name, j, {out_valid, in_ready, busy, out_last}, {3'b101, (j == N - 1)});
            end
            n_cmp++;
            if (out_data !== ed[j] || out_idx !== ei[j]) begin
                n_err++;
                $display("FAIL %s drain_word %0d: got data=%0d idx=%0d want data=%0d idx=%0d",
                         name, j, out_data, out_idx, ed[j], ei[j]);
            end
            @(posedge clk); #1;
            cyc++;
            if (out_ready) j++;
        end
        if (j < N) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s drain_timeout: got %0d words want %0d", name, j, N);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if ({out_valid, in_ready, busy, out_last, out_data, out_idx} !== {4'b0100, {W{1'b0}}, {IW{1'b0}}}) begin
            n_err++;
            $display("FAIL %s back_to_load: valid/ready/busy/last=%b data=%0d idx=%0d want 0100/0/0",
                     name, {out_valid, in_ready, busy, out_last}, out_data, out_idx);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({in_ready, out_valid, out_last, busy, out_data, out_idx} !== {4'b1000, {W{1'b0}}, {IW{1'b0}}}) begin
            n_err++;
            $display("FAIL %s reset_outputs: ready/valid/last/busy=%b data=%0d idx=%0d want 1000/0/0",
                     name, {in_ready, out_valid, out_last, busy}, out_data, out_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset_released");
    endtask

    task automatic test_ascending();
        logic [W-1:0] v [N];
        v = '{32'd4, 32'd1, 32'd2, 32'd5, 32'd3, 32'd7};
        run_frame(v, 1'b0, 0, "ascending");
    endtask

    task automatic test_stability();
        logic [W-1:0] v [N];
        v = '{32'd16, 32'd11, 32'd12, 32'd16, 32'd12, 32'd10};
        run_frame(v, 1'b0, 0, "stability");
    endtask

    task automatic test_descending_vector();
        logic [W-1:0] v [N];
        v = '{32'd10, 32'd17, 32'd18, 32'd1, 32'd16, 32'd4};
        run_frame(v, 1'b0, 0, "desc_vector");
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [N];
        v = '{32'd1, 32'd16, 32'd12, 32'd14, 32'd15, 32'd8};
        run_frame(v, 1'b0, 2, "backpressure");
    endtask

    task automatic test_extremes();
        logic [W-1:0] v [N];
        v = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0};
        run_frame(v, 1'b1, 1, "extremes");
    endtask

    task automatic test_reset_mid_sort();
        logic [W-1:0] v [N];
        v = '{32'd3, 32'd4, 32'd9, 32'd19, 32'd2, 32'd9};
        load_words(v, 1'b0, "reset_mid_sort");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_sort");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        v = '{32'd13, 32'd9, 32'd2, 32'd1, 32'd18, 32'd20};
        run_frame(v, 1'b0, 0, "after_reset_sort");
    endtask

    task automatic test_reset_mid_load();
        logic [W-1:0] v [N];
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd100 + W'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_load");
        @(posedge clk); #1;
        rst = 1'b0;
        v = '{32'd50, 32'd40, 32'd30, 32'd20, 32'd10, 32'd0};
        run_frame(v, 1'b0, 0, "after_reset_load");
    endtask

    task automatic test_random();
        logic [W-1:0] v [N];
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N; i++)
                v[i] = (f % 2 == 0) ? W'($urandom_range(7)) : W'($urandom);
            run_frame(v, 1'b1, 1, $sformatf("random_%0d", f));
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_stability();
        test_descending_vector();
        test_backpressure();
        test_extremes();
        test_reset_mid_sort();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
